// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single shared memory port arbiter for the fetch and load/store paths
// Optional MEM_ARB_STARVE_GUARD_EN limits how many data grants may pass a waiting fetch.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [3:0]  d_be_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    output logic        d_gnt_o,
    output logic        d_rvalid_o,
    output logic [31:0] d_rdata_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        owner_q, owner_d;     // 1 = load/store path owns the transaction
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        if_gnt_c, d_gnt_c;
    logic        fetch_force;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_q, starve_d;

    assign fetch_force = if_req_i && (starve_q == LIMIT_C);

    // Counts data grants that overtook a pending fetch; any idle gap in fetch demand clears it.
    always_comb begin
        starve_d = starve_q;
        if (state_q == IDLE) begin
            if (!if_req_i || if_gnt_c) begin
                starve_d = '0;
            end else if (d_gnt_c && (starve_q != LIMIT_C)) begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    logic unused_starve_limit;
    assign unused_starve_limit = ^STARVE_LIMIT;
    assign fetch_force         = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        be_d        = be_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        if_gnt_c    = 1'b0;
        d_gnt_c     = 1'b0;
        mem_req_o   = 1'b0;
        if_rvalid_o = 1'b0;
        d_rvalid_o  = 1'b0;
        if_rdata_o  = '0;
        d_rdata_o   = '0;
        case (state_q)
            IDLE: begin
                if (d_req_i && !fetch_force) begin
                    d_gnt_c = 1'b1;
                    owner_d = 1'b1;
                    we_d    = d_we_i;
                    be_d    = d_be_i;
                    addr_d  = d_addr_i;
                    wdata_d = d_wdata_i;
                    state_d = REQ;
                end else if (if_req_i) begin
                    if_gnt_c = 1'b1;
                    owner_d  = 1'b0;
                    we_d     = 1'b0;
                    be_d     = 4'hF;
                    addr_d   = if_addr_i;
                    wdata_d  = '0;
                    state_d  = REQ;
                end
            end
            REQ: begin
                mem_req_o = 1'b1;
                if (mem_gnt_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid_i) begin
                    if (owner_q) begin
                        d_rvalid_o = 1'b1;
                        d_rdata_o  = mem_rdata_i;
                    end else begin
                        if_rvalid_o = 1'b1;
                        if_rdata_o  = mem_rdata_i;
                    end
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Grants are combinational from the requests, so mask them while reset is held.
    assign if_gnt_o    = if_gnt_c & rst_n_i;
    assign d_gnt_o     = d_gnt_c & rst_n_i;
    assign mem_we_o    = we_q;
    assign mem_be_o    = be_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
// Transaction-level reference model plus directed literal checks.
module tb_mem_port_arbiter;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif
    localparam int LIMIT = 4;

    logic        clk, rst_n;
    logic        if_req, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [3:0]  d_be;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
        .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
        .d_req_i(d_req), .d_we_i(d_we), .d_be_i(d_be), .d_addr_i(d_addr),
        .d_wdata_i(d_wdata), .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
        .mem_rdata_i(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // reference model state
    bit          busy, accepted, own_d;
    bit          e_we;
    logic [3:0]  e_be;
    logic [31:0] e_addr, e_wdata;
    int          starve;
    bit          seen_if_gnt, seen_d_gnt;

    // memory model state
    int          gnt_wait, resp_lat, wait_cnt, resp_cnt;
    logic [31:0] resp_data;
    bit          force_rvalid;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h0000_0010) return 32'h0050_0093;
        return a ^ 32'h1234_5678;
    endfunction

    task automatic check_cycle();
        bit exp_ig, exp_dg, exp_mreq, exp_irv, exp_drv, force_if;
        seen_if_gnt = if_gnt;
        seen_d_gnt  = d_gnt;
        if (!rst_n) begin
            check("rst_if_gnt", {31'b0, if_gnt}, 0);
            check("rst_d_gnt", {31'b0, d_gnt}, 0);
            check("rst_if_rvalid", {31'b0, if_rvalid}, 0);
            check("rst_d_rvalid", {31'b0, d_rvalid}, 0);
            check("rst_if_rdata", if_rdata, 0);
            check("rst_d_rdata", d_rdata, 0);
            check("rst_mem_req", {31'b0, mem_req}, 0);
            check("rst_mem_attr", {27'b0, mem_we, mem_be} | mem_addr | mem_wdata, 0);
            busy = 0; accepted = 0; starve = 0;
            resp_cnt = 0; wait_cnt = 0;
            return;
        end
        exp_ig = 0;
        exp_dg = 0;
        if (!busy) begin
            force_if = GUARD && if_req && (starve == LIMIT);
            if (d_req && !force_if) exp_dg = 1;
            else if (if_req) exp_ig = 1;
        end
        exp_mreq = busy && !accepted;
        exp_irv  = busy && accepted && mem_rvalid && !own_d;
        exp_drv  = busy && accepted && mem_rvalid && own_d;
        check("if_gnt", {31'b0, if_gnt}, {31'b0, exp_ig});
        check("d_gnt", {31'b0, d_gnt}, {31'b0, exp_dg});
        check("mem_req", {31'b0, mem_req}, {31'b0, exp_mreq});
        if (exp_mreq) begin
            check("mem_we", {31'b0, mem_we}, {31'b0, e_we});
            check("mem_be", {28'b0, mem_be}, {28'b0, e_be});
            check("mem_addr", mem_addr, e_addr);
            check("mem_wdata", mem_wdata, e_wdata);
        end
        check("if_rvalid", {31'b0, if_rvalid}, {31'b0, exp_irv});
        check("d_rvalid", {31'b0, d_rvalid}, {31'b0, exp_drv});
        check("if_rdata", if_rdata, exp_irv ? mem_rdata : 32'h0);
        if (!(exp_drv && e_we)) check("d_rdata", d_rdata, exp_drv ? mem_rdata : 32'h0);
        if (!busy) begin
            if (!if_req || exp_ig) starve = 0;
            else if (exp_dg && starve < LIMIT) starve++;
        end
        if (exp_irv || exp_drv) busy = 0;
        else if (exp_mreq && mem_gnt) accepted = 1;
        if (exp_dg) begin
            busy = 1; accepted = 0; own_d = 1;
            e_we = d_we; e_be = d_be; e_addr = d_addr; e_wdata = d_wdata;
        end else if (exp_ig) begin
            busy = 1; accepted = 0; own_d = 0;
            e_we = 0; e_be = 4'hF; e_addr = if_addr; e_wdata = 0;
        end
        if (mem_req && mem_gnt) begin
            resp_cnt  = resp_lat;
            resp_data = mem_we ? 32'h0 : mem_fn(mem_addr);
        end
    endtask

    task automatic mem_drive();
        mem_gnt    = 0;
        mem_rvalid = 0;
        mem_rdata  = 32'hA5A5_0000 | (cyc & 32'hFFFF);
        if (force_rvalid) begin
            mem_rvalid   = 1;
            force_rvalid = 0;
        end else if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                mem_rvalid = 1;
                mem_rdata  = resp_data;
            end
        end else if (mem_req) begin
            if (wait_cnt >= gnt_wait) begin
                mem_gnt  = 1;
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end
    endtask

    task automatic cyc_end();
        #1;
        check_cycle();
        @(posedge clk);
        #1;
        mem_drive();
        cyc++;
    endtask

    initial begin
        int dcnt;
        bit if_seen;
        rst_n = 0; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_be = 0;
        d_addr = 0; d_wdata = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
        gnt_wait = 0; resp_lat = 1; wait_cnt = 0; resp_cnt = 0; force_rvalid = 0;
        busy = 0; accepted = 0; own_d = 0; starve = 0; resp_data = 0;
        e_we = 0; e_be = 0; e_addr = 0; e_wdata = 0;
        cyc_end();
        cyc_end();
        rst_n = 1;
        cyc_end();

        // fetch, zero-wait memory
        if_req = 1; if_addr = 32'h10;
        #1;
        check("t1_if_gnt_T", {31'b0, if_gnt}, 1);
        cyc_end();
        if_req = 0; if_addr = 32'hFFFF_FFF0;
        #1;
        check("t1_mem_req_T1", {31'b0, mem_req}, 1);
        check("t1_mem_addr_T1", mem_addr, 32'h10);
        check("t1_mem_be_T1", {28'b0, mem_be}, 32'hF);
        cyc_end();
        #1;
        check("t1_if_rvalid_T2", {31'b0, if_rvalid}, 1);
        check("t1_if_rdata_T2", if_rdata, 32'h0050_0093);
        cyc_end();
        cyc_end();

        // store with mem_gnt delayed 3 cycles
        gnt_wait = 3;
        d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
        #1;
        check("t2_d_gnt", {31'b0, d_gnt}, 1);
        cyc_end();
        d_req = 0; d_we = 0; d_be = 0; d_addr = 32'h7; d_wdata = 0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("t2_mem_req_held", {31'b0, mem_req}, 1);
            check("t2_mem_we", {31'b0, mem_we}, 1);
            check("t2_mem_be", {28'b0, mem_be}, 32'h3);
            check("t2_mem_addr", mem_addr, 32'h100);
            check("t2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
            cyc_end();
        end
        #1;
        check("t2_mem_req_drop", {31'b0, mem_req}, 0);
        check("t2_d_rvalid", {31'b0, d_rvalid}, 1);
        check("t2_if_rvalid", {31'b0, if_rvalid}, 0);
        cyc_end();
        gnt_wait = 0;
        cyc_end();

        // simultaneous requests: data first, fetch three cycles later
        d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h200;
        if_req = 1; if_addr = 32'h20;
        #1;
        check("t3_d_gnt_first", {31'b0, d_gnt}, 1);
        check("t3_if_gnt_blocked", {31'b0, if_gnt}, 0);
        cyc_end();
        d_req = 0;
        cyc_end();
        #1;
        check("t3_d_rdata", d_rdata, 32'h1234_5478);
        check("t3_if_rvalid_quiet", {31'b0, if_rvalid}, 0);
        cyc_end();
        #1;
        check("t3_if_gnt_T3", {31'b0, if_gnt}, 1);
        cyc_end();
        if_req = 0;
        cyc_end();
        #1;
        check("t3_if_rdata", if_rdata, 32'h1234_5658);
        check("t3_d_rvalid_quiet", {31'b0, d_rvalid}, 0);
        cyc_end();
        cyc_end();

        // reset while waiting for a response
        resp_lat = 3;
        d_req = 1; d_we = 0; d_addr = 32'h300;
        cyc_end();
        d_req = 0;
        cyc_end();
        d_req = 1; if_req = 1;
        rst_n = 0;
        #1;
        check("t4_async_d_gnt", {31'b0, d_gnt}, 0);
        check("t4_async_if_gnt", {31'b0, if_gnt}, 0);
        check("t4_async_mem_addr", mem_addr, 0);
        cyc_end();
        cyc_end();
        d_req = 0; if_req = 0; rst_n = 1; resp_lat = 1;
        cyc_end();
        force_rvalid = 1;
        cyc_end();
        #1;
        check("t4_idle_rvalid_seen", {31'b0, mem_rvalid}, 1);
        check("t4_idle_d_rvalid", {31'b0, d_rvalid}, 0);
        check("t4_idle_if_rvalid", {31'b0, if_rvalid}, 0);
        check("t4_idle_d_rdata", d_rdata, 0);
        cyc_end();

        // both requesters held high
        dcnt = 0; if_seen = 0;
        d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h400;
        if_req = 1; if_addr = 32'h40;
        for (int k = 0; k < 30; k++) begin
            cyc_end();
            if (seen_if_gnt) begin
                if_seen = 1;
                break;
            end
            if (seen_d_gnt) begin
                dcnt++;
                d_addr = d_addr + 4;
            end
        end
        if (GUARD) begin
            check("t5_d_gnts_before_fetch", dcnt, LIMIT);
            check("t5_fetch_granted", {31'b0, if_seen}, 1);
        end else begin
            check("t5_d_gnts_strict", dcnt, 10);
            check("t5_fetch_starved", {31'b0, if_seen}, 0);
        end
        d_req = 0;
        if (if_seen) if_req = 0;
        for (int k = 0; k < 8; k++) begin
            cyc_end();
            if (seen_if_gnt) if_req = 0;
        end

        // mixed traffic, model-checked every cycle
        for (int k = 0; k < 240; k++) begin
            if (seen_d_gnt) d_req = 0;
            if (seen_if_gnt) if_req = 0;
            if (k % 30 == 0) begin
                gnt_wait = $urandom_range(0, 3);
                resp_lat = $urandom_range(1, 3);
            end
            if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req = 1; d_we = 1'($urandom); d_be = 4'($urandom);
                d_addr = $urandom; d_wdata = $urandom;
            end
            if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1; if_addr = $urandom;
            end
            cyc_end();
        end
        d_req = 0; if_req = 0;
        for (int k = 0; k < 16; k++) begin
            cyc_end();
        end
        check("final_idle", {31'b0, busy}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single shared memory port between the instruction-fetch path (program counter / instruction memory side) and the load/store path of the RV32I core. It accepts one request at a time, forwards it to memory, waits for the response, and routes read data back to the owning requester. It sits between the core's fetch/LSU logic and the unified memory.

## Interface
- STARVE_LIMIT, 4: consecutive data grants allowed while fetch waits; only used with the configuration macro.
- clk  in  1  core clock
- rst_n  in  1  reset; asynchronous, active-low
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  32  fetch byte address
- if_gnt  out  1  fetch request accepted (1-cycle pulse)
- if_rvalid  out  1  fetch response valid
- if_rdata  out  32  fetched instruction word
- d_req  in  1  load/store request; held with attributes until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_be  in  4  byte enables
- d_addr  in  32  data byte address
- d_wdata  in  32  store data
- d_gnt  out  1  data request accepted (1-cycle pulse)
- d_rvalid  out  1  load data valid / store acknowledged
- d_rdata  out  32  load data
- mem_req, mem_we  out  1  memory request / write
- mem_be  out  4  memory byte enables
- mem_addr, mem_wdata  out  32  memory address / write data
- mem_gnt  in  1  memory accepted mem_req
- mem_rvalid  in  1  memory response; earliest 1 cycle after mem_gnt
- mem_rdata  in  32  memory read data

## Operation
- States: IDLE, REQ, WAIT. One outstanding transaction total.
- IDLE: if any req, select winner; assert winner's gnt combinationally this cycle; latch owner, we, be, addr, wdata into registers; go REQ. No req: stay.
- Priority: d_req over if_req (strict, unless macro below).
- Fetch latched as we=0, be=4'hF, wdata=0.
- REQ: mem_req=1 with latched attributes; on mem_gnt go WAIT. mem_rvalid in REQ ignored.
- WAIT: mem_req=0; on mem_rvalid, pass mem_rdata to owner's rdata and pulse owner's rvalid same cycle (combinational); go IDLE.
- Stores complete on mem_rvalid too; d_rdata then don't-care.
- Non-owner rvalid always 0; rdata outputs 0 when rvalid=0.
- mem_rvalid in IDLE: ignored, no output change.
- Addresses and data pass unchanged; no alignment check.

## Timing
- Reset: state IDLE; all outputs and latched registers 0; starve counter 0.
- if_gnt/d_gnt at cycle T (IDLE), mem_req from T+1.
- Zero-wait memory: mem_gnt T+1, mem_rvalid T+2, X_rvalid T+2, IDLE T+3, next gnt earliest T+3. Back-to-back throughput: one transaction per 3 cycles.
- mem_req stays high with stable attributes until mem_gnt.
- Both reqs in same IDLE cycle: exactly one gnt; loser keeps req, served at next IDLE.
- Reset mid-transaction: immediate IDLE, in-flight response lost; memory is reset by the same rst_n.

## Configuration
- MEM_ARB_STARVE_GUARD_EN defined: counter counts data grants issued while if_req=1; when counter == STARVE_LIMIT and if_req=1, next grant goes to fetch even if d_req=1. Counter clears on any fetch grant and when if_req=0 in IDLE; saturates at STARVE_LIMIT.
- Not defined: strict data priority; counter logic absent.

## Test plan
- Reset, then if_req, if_addr=0x00000010, mem zero-wait returning 0x00500093 -> if_gnt at T, mem_addr=0x10 mem_be=4'hF at T+1, if_rvalid with 0x00500093 at T+2.
- Store d_addr=0x100, d_be=4'b0011, d_wdata=0xDEADBEEF, mem_gnt delayed 3 cycles -> mem_req held 4 cycles with stable mem_we=1/be/addr/wdata; d_rvalid on ack; if_rvalid stays 0.
- if_req and d_req together -> d_gnt first, if_gnt 3 cycles later (zero-wait), responses routed correctly.
- Assert rst_n=0 in WAIT -> all outputs 0 asynchronously; later mem_rvalid in IDLE produces no rvalid.
- With MEM_ARB_STARVE_GUARD_EN, STARVE_LIMIT=4, d_req and if_req held high -> 4 d_gnt then 1 if_gnt; without macro, if_gnt never occurs while d_req high.
